ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared single-port 256-entry data RAM.
- The RAM has a synchronous write and a combinational (asynchronous) read.
- Typical requesters: CPU core load/store unit on port 0, program loader/DMA on port 1.
- Serialises accesses and owns the RAM control pins:
  - latches the winning request;
  - drives one access cycle;
  - captures read data and returns a one-cycle done pulse to the winner.

Parameters:
- DATA_WIDTH, 8, width of RAM words and requester data buses.
- ADDR_WIDTH, 8, RAM address width (depth = 2**ADDR_WIDTH).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- p0_req  in  1  port 0 request; held high until p0_done.
- p0_we  in  1  port 0: 1 = write, 0 = read.
- p0_addr  in  ADDR_WIDTH  port 0 address.
- p0_wdata  in  DATA_WIDTH  port 0 write data.
- p0_rdata  out  DATA_WIDTH  port 0 read data, valid when p0_done is high; holds until the next port 0 read.
- p0_done  out  1  port 0 one-cycle completion pulse.
- p1_req, p1_we, p1_addr, p1_wdata, p1_rdata, p1_done: same as port 0, for port 1.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_din  out  DATA_WIDTH  RAM write data.
- ram_dout  in  DATA_WIDTH  RAM combinational read data.

Behaviour:
- Reset (async, rst_n=0), effective immediately:
  - state=IDLE, ram_we=0, ram_addr=0, ram_din=0;
  - p0_done=p1_done=0, p0_rdata=p1_rdata=0;
  - grant register=0, last_grant=1 (port 0 wins the first tie).
- FSM, 3 states:
  - IDLE:
    - if any req is high: pick the winner and latch winner's we/addr/wdata plus grant id; go ACCESS;
    - else stay in IDLE.
  - ACCESS, exactly 1 cycle:
    - ram_addr = latched addr, ram_din = latched wdata, ram_we = latched we;
    - at the closing edge: if read, capture ram_dout into the winner's rdata register;
    - last_grant <= winner; go DONE.
  - DONE, 1 cycle: winner's pX_done=1; go IDLE.
- ram_we is high only in ACCESS. ram_addr and ram_din hold their latched values in all other states.
- Latency: req sampled high at edge k → ACCESS during cycle k..k+1 → done high cycle k+1..k+2.
  - Read data is visible on pX_rdata in the same cycle as done.
- Throughput: one transaction per 3 cycles.
- Requests are sampled only in IDLE.
  - req high during ACCESS/DONE is not sampled.
  - A requester keeping req high after done issues a new back-to-back transaction on the next IDLE.
- Requesters keep we/addr/wdata stable while req is high; only the IDLE-cycle values are used.
- Arbitration with ARB_RR_EN defined:
  - both requesting: the port != last_grant wins;
  - one requesting: that port wins.
- Writes never modify pX_rdata. A read by one port never modifies the other port's rdata.
- done is asserted only for the granted port; the loser waits in IDLE for the next sampling.
- Same-address write then read (any ports): the read returns the written value, since the write commits before the next ACCESS.
- Reset mid-transaction:
  - transaction aborted, no done pulse;
  - if in ACCESS, ram_we drops immediately and the write is not guaranteed;
  - requesters reissue after reset.
- Address wraps naturally at ADDR_WIDTH; no range checks.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration via last_grant, as above; no requester starves.
- Undefined:
  - fixed priority, port 0 always wins when both request;
  - last_grant register not implemented;
  - port 1 may starve under continuous port 0 traffic.

Test Plan:
- Reset, then p0 write addr 0x10 data 0xA5:
  - ram_we=1 in exactly one cycle with ram_addr=0x10, ram_din=0xA5;
  - p0_done pulses 2 cycles after req sampled.
- p1 read addr 0x10 after the above:
  - p1_rdata=0xA5 with p1_done;
  - p0_rdata unchanged (0x00).
- p0 and p1 request in the same IDLE cycle, continuously:
  - with ARB_RR_EN: grants alternate 0,1,0,1 and each port gets done every 6 cycles;
  - without ARB_RR_EN: only port 0 completes while p0_req is held.
- Back-to-back p0: write 0x00←0x3C, then read 0x00 with req never dropped: second done returns 0x3C, 3 cycles after the first done.
- Assert rst_n=0 during ACCESS of a write:
  - ram_we and done drop immediately;
  - state IDLE after release;
  - next request completes normally.
- Read addr 0xFF and write addr 0xFF: correct ram_addr=0xFF; no wrap errors; rdata matches preloaded RAM content.

Source files
------------

// File: rtl/ram_arbiter.sv
`timescale 1ns/1ps
// ram_arbiter: two-requester arbiter/sequencer for a single-port RAM with
// synchronous write and combinational read. Each transaction takes three
// cycles: IDLE (sample and latch) -> ACCESS (one RAM cycle) -> DONE (pulse).
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   pX_req/we/addr/     request from port X (0 = CPU LSU, 1 = loader/DMA);
//   pX_wdata            req held high until pX_done, fields stable meanwhile
//   pX_rdata, pX_done   read data register (holds until next read by that
//                       port) and one-cycle completion pulse
//   ram_we/addr/din     RAM control, driven from registers
//   ram_dout            RAM combinational read data
//
// Build option: define ARB_RR_EN for round-robin arbitration between the
// two ports; otherwise port 0 has fixed priority and port 1 can starve.
module ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_done,

    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_done,

    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                  state_q,    state_d;
    logic                    grant_q,    grant_d;     // 0 = port 0, 1 = port 1
    logic                    ram_we_q,   ram_we_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_din_q,  ram_din_d;
    logic                    p0_done_q,  p0_done_d;
    logic                    p1_done_q,  p1_done_d;
    logic [DATA_WIDTH-1:0]   p0_rdata_q, p0_rdata_d;
    logic [DATA_WIDTH-1:0]   p1_rdata_q, p1_rdata_d;
`ifdef ARB_RR_EN
    logic                    last_grant_q, last_grant_d;
`endif

    logic                    any_req;
    logic                    winner;

    // Winner selection, only meaningful while any_req is high.
    always_comb begin
        any_req = p0_req | p1_req;
`ifdef ARB_RR_EN
        // On a tie the port that was not served last goes next; otherwise the
        // sole requester wins (p1_req is 0 exactly when only port 0 asks).
        winner = (p0_req & p1_req) ? ~last_grant_q : p1_req;
`else
        winner = ~p0_req;
`endif
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ram_we_d   = 1'b0;          // write enable lives only in ACCESS
        ram_addr_d = ram_addr_q;    // address/data hold between transactions
        ram_din_d  = ram_din_q;
        p0_done_d  = 1'b0;
        p1_done_d  = 1'b0;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
`ifdef ARB_RR_EN
        last_grant_d = last_grant_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    // Latch the winner's request straight into the RAM pin
                    // registers so ACCESS drives them glitch-free.
                    grant_d    = winner;
                    ram_we_d   = winner ? p1_we    : p0_we;
                    ram_addr_d = winner ? p1_addr  : p0_addr;
                    ram_din_d  = winner ? p1_wdata : p0_wdata;
                    state_d    = S_ACCESS;
                end
            end

            S_ACCESS: begin
                // ram_we_q is the latched direction of this transaction.
                if (!ram_we_q) begin
                    if (grant_q) begin
                        p1_rdata_d = ram_dout;
                    end else begin
                        p0_rdata_d = ram_dout;
                    end
                end
                p0_done_d = ~grant_q;
                p1_done_d = grant_q;
`ifdef ARB_RR_EN
                last_grant_d = grant_q;
`endif
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            grant_q    <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            p0_done_q  <= 1'b0;
            p1_done_q  <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
`ifdef ARB_RR_EN
            // Pretend port 1 was served last so port 0 wins the first tie.
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            p0_done_q  <= p0_done_d;
            p1_done_q  <= p1_done_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
`ifdef ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign p0_done  = p0_done_q;
    assign p1_done  = p1_done_q;
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for ram_arbiter: a transaction-level model predicts grant
// order, RAM contents and read data; monitors compare on ram_we and done.
module tb_ram_arbiter;

    localparam time P = 10;

    logic       clk;
    logic       rst_n;
    logic       p0_req, p0_we, p1_req, p1_we;
    logic [7:0] p0_addr, p0_wdata, p0_rdata, p1_addr, p1_wdata, p1_rdata;
    logic       p0_done, p1_done;
    logic       ram_we;
    logic [7:0] ram_addr, ram_din, ram_dout;

    // Requester drive state, indexed by port.
    logic       req_v [2];
    logic       we_v  [2];
    logic [7:0] addr_v[2];
    logic [7:0] wd_v  [2];

    assign p0_req = req_v[0];  assign p0_we = we_v[0];
    assign p0_addr = addr_v[0]; assign p0_wdata = wd_v[0];
    assign p1_req = req_v[1];  assign p1_we = we_v[1];
    assign p1_addr = addr_v[1]; assign p1_wdata = wd_v[1];

    ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_done(p0_done),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_done(p1_done),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // The RAM itself: synchronous write, combinational read.
    logic [7:0] ram [0:255];
    always @(posedge clk) if (ram_we) ram[ram_addr] = ram_din;
    assign ram_dout = ram[ram_addr];

    initial clk = 1'b0;
    always #(P/2) clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int         port;
        time        t;
        logic [7:0] addr;
        logic [7:0] r0;
        logic [7:0] r1;
    } done_t;
    typedef struct {
        time        t;
        logic [7:0] addr;
        logic [7:0] din;
    } wr_t;

    done_t dq[$];
    wr_t   wq[$];

    bit [7:0] m_mem [256];
    bit [7:0] m_rd  [2];
    int       busy;          // upcoming edges at which the arbiter is not sampling
`ifdef ARB_RR_EN
    int       m_last;
`endif
    logic     mon_off;

    task automatic model_reset();
        busy = 0;
        m_rd[0] = 8'h00;
        m_rd[1] = 8'h00;
`ifdef ARB_RR_EN
        m_last = 1;
`endif
        dq.delete();
        wq.delete();
    endtask

    // Called once per negedge after inputs for the next edge are settled.
    task automatic model_step();
        int    w;
        done_t d;
        wr_t   wr;
        if (busy > 0) begin
            busy--;
            return;
        end
        if (!req_v[0] && !req_v[1]) return;
        if (req_v[0] && req_v[1]) begin
`ifdef ARB_RR_EN
            w = (m_last == 0) ? 1 : 0;
`else
            w = 0;
`endif
        end else begin
            w = req_v[1] ? 1 : 0;
        end
`ifdef ARB_RR_EN
        m_last = w;
`endif
        if (we_v[w]) begin
            m_mem[addr_v[w]] = wd_v[w];
            wr.t = $time + P; wr.addr = addr_v[w]; wr.din = wd_v[w];
            wq.push_back(wr);
        end else begin
            m_rd[w] = m_mem[addr_v[w]];
        end
        d.port = w; d.t = $time + 2*P; d.addr = addr_v[w];
        d.r0 = m_rd[0]; d.r1 = m_rd[1];
        dq.push_back(d);
        busy = 2;
    endtask

    // ---------------- monitor ----------------
    done_t md;
    wr_t   mw;
    always @(negedge clk) begin
        if (rst_n && !mon_off) begin
            if (wq.size() > 0 && wq[0].t < $time) begin
                chk("missing_ram_we", 0, 1);
                mw = wq.pop_front();
            end
            if (ram_we) begin
                if (wq.size() == 0) chk("unexpected_ram_we", 1, 0);
                else begin
                    mw = wq.pop_front();
                    chk("ram_we_time", $time, mw.t);
                    chk("ram_addr_wr", ram_addr, mw.addr);
                    chk("ram_din", ram_din, mw.din);
                end
            end
            if (dq.size() > 0 && dq[0].t < $time) begin
                chk("missing_done", 0, 1);
                md = dq.pop_front();
            end
            if (p0_done && p1_done) chk("both_done", 1, 0);
            else if (p0_done || p1_done) begin
                if (dq.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    md = dq.pop_front();
                    chk("done_port", p1_done ? 1 : 0, md.port);
                    chk("done_time", $time, md.t);
                    chk("p0_rdata", p0_rdata, md.r0);
                    chk("p1_rdata", p1_rdata, md.r1);
                    chk("ram_addr_hold", ram_addr, md.addr);
                    chk("ram_we_in_done", ram_we, 0);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic done_of(input int p);
        return (p == 1) ? p1_done : p0_done;
    endfunction

    task automatic set_op(input int p, input logic we, input logic [7:0] a, input logic [7:0] d);
        we_v[p] = we; addr_v[p] = a; wd_v[p] = d;
    endtask

    task automatic rand_op(input int p);
        logic [7:0] a;
        a = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
        set_op(p, 1'($urandom_range(0, 1)), a, 8'($urandom));
    endtask

    // Single transaction on one port; returns at the negedge where done is seen.
    task automatic do_op(input int p, input logic we, input logic [7:0] a, input logic [7:0] d);
        bit seen = 0;
        @(negedge clk);
        set_op(p, we, a, d);
        req_v[p] = 1'b1;
        model_step();
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clk);
            if (done_of(p)) begin
                seen = 1;
                req_v[p] = 1'b0;
            end
            model_step();
        end
        if (!seen) begin
            chk("do_op_timeout", 0, 1);
            req_v[p] = 1'b0;
        end
    endtask

    time t1, t2;
    int  c0, c1;
    bit  drained;

    initial begin
        mon_off = 1'b0;
        for (int p = 0; p < 2; p++) begin
            req_v[p] = 1'b0; we_v[p] = 1'b0; addr_v[p] = 8'h00; wd_v[p] = 8'h00;
        end
        model_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_din", ram_din, 0);
        chk("rst_p0_done", p0_done, 0);
        chk("rst_p1_done", p1_done, 0);
        chk("rst_p0_rdata", p0_rdata, 0);
        chk("rst_p1_rdata", p1_rdata, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Write then cross-port read of the same address.
        do_op(0, 1'b1, 8'h10, 8'hA5);
        do_op(1, 1'b0, 8'h10, 8'h00);
        chk("p1_read_10", p1_rdata, 8'hA5);
        chk("p0_rdata_untouched", p0_rdata, 8'h00);

        // Back-to-back on port 0 without dropping req.
        @(negedge clk);
        set_op(0, 1'b1, 8'h00, 8'h3C);
        req_v[0] = 1'b1;
        model_step();
        t1 = 0; t2 = 0;
        for (int n = 0; n < 30 && t2 == 0; n++) begin
            @(negedge clk);
            if (p0_done) begin
                if (t1 == 0) begin
                    t1 = $time;
                    set_op(0, 1'b0, 8'h00, 8'h00);
                end else begin
                    t2 = $time;
                    chk("b2b_rdata", p0_rdata, 8'h3C);
                    req_v[0] = 1'b0;
                end
            end
            model_step();
        end
        req_v[0] = 1'b0;
        chk("b2b_gap", longint'(t2) - longint'(t1), 3*P);

        // Both ports requesting continuously for 8 transaction slots.
        @(negedge clk);
        set_op(0, 1'b0, 8'h10, 8'h00);
        set_op(1, 1'b0, 8'h00, 8'h00);
        req_v[0] = 1'b1; req_v[1] = 1'b1;
        c0 = 0; c1 = 0;
        model_step();
        for (int i = 1; i < 24; i++) begin
            @(negedge clk);
            if (p0_done) c0++;
            if (p1_done) c1++;
            model_step();
        end
        @(negedge clk);
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        model_step();
`ifdef ARB_RR_EN
        chk("contend_p0_count", c0, 4);
        chk("contend_p1_count", c1, 4);
`else
        chk("contend_p0_count", c0, 8);
        chk("contend_p1_count", c1, 0);
`endif

        // Reset during the ACCESS cycle of a write.
        @(negedge clk);
        mon_off = 1'b1;
        set_op(0, 1'b1, 8'h20, 8'h77);
        req_v[0] = 1'b1;
        @(negedge clk);
        chk("abort_ram_we_in_access", ram_we, 1);
        rst_n = 1'b0;
        req_v[0] = 1'b0;
        #1;
        chk("abort_ram_we_drop", ram_we, 0);
        chk("abort_p0_done", p0_done, 0);
        chk("abort_p1_done", p1_done, 0);
        chk("abort_p0_rdata", p0_rdata, 0);
        chk("abort_ram_addr", ram_addr, 0);
        @(negedge clk);
        chk("abort_no_done", p0_done | p1_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        mon_off = 1'b0;
        do_op(0, 1'b0, 8'h10, 8'h00);
        chk("post_reset_read", p0_rdata, 8'hA5);

        // Preload the address pool (0x00..0x0F and 0xFF) through port 1.
        for (int a = 0; a < 17; a++)
            do_op(1, 1'b1, (a == 16) ? 8'hFF : 8'(a), 8'($urandom));
        do_op(0, 1'b0, 8'hFF, 8'h00);
        chk("read_ff_preload", p0_rdata, m_mem[255]);
        chk("ram_addr_ff", ram_addr, 8'hFF);

        // Random traffic on both ports.
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (req_v[p] && done_of(p)) begin
                    if ($urandom_range(0, 1) == 1) rand_op(p);
                    else req_v[p] = 1'b0;
                end else if (!req_v[p] && $urandom_range(0, 2) == 0) begin
                    rand_op(p);
                    req_v[p] = 1'b1;
                end
            end
            model_step();
        end

        // Drain: let outstanding requests finish, issue nothing new.
        drained = 0;
        for (int i = 0; i < 100 && !drained; i++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++)
                if (req_v[p] && done_of(p)) req_v[p] = 1'b0;
            model_step();
            if (!req_v[0] && !req_v[1]) drained = 1;
        end
        chk("drain_reqs_released", drained, 1);
        repeat (4) @(negedge clk);
        chk("drain_done_queue_empty", dq.size(), 0);
        chk("drain_write_queue_empty", wq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
